pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
//  Parametrised program-counter unit: registers the fetch address and picks the next one.
//  Sources: sequential step, branch, jump, call or return.
//  Adds a synchronous reset, a stall hold, branch/jump redirection and an optional
//  return-address stack (RAS).
//  pc_out drives the instruction-memory address; pc_plus feeds the datapath link value.
// PARAMETERS
//  ADDR_W    32  width of every address port and of the PC register
//  STEP      1   sequential increment (1 = word-addressed instruction memory)
//  RESET_VEC 0   pc_out value after reset
//  RAS_DEPTH 4   return-address stack entries (>=2); used only with PC_RAS_EN
// PORTS
//  clk           in   1       clock; all state updates on posedge
//  rst           in   1       reset, synchronous, active-high
//  stall         in   1       hold PC and RAS; all other control inputs ignored
//  branch_taken  in   1       redirect to branch_target
//  branch_target in   ADDR_W  branch destination
//  jump          in   1       redirect to jump_target
//  call          in   1       redirect to jump_target and push pc_plus
//  jump_target   in   ADDR_W  jump/call destination
//  ret           in   1       redirect to popped RAS top
//  pc_out        out  ADDR_W  registered fetch address
//  pc_plus       out  ADDR_W  comb: pc_out + STEP
//  pc_next       out  ADDR_W  comb: the value pc_out takes at the next posedge
//  ras_empty     out  1       comb: RAS holds 0 entries
//  ras_full      out  1       comb: RAS holds RAS_DEPTH entries
//  ret_fault     out  1       registered 1-cycle pulse: ret issued with the RAS empty
// BEHAVIOUR
//  - Reset: pc_out=RESET_VEC, RAS count=0, ret_fault=0.
//    Applies mid-operation and discards RAS contents.
//  - Priority per cycle: rst > stall > ret > call > jump > branch_taken > sequential.
//  - Sequential: pc_out <= pc_out+STEP, modulo 2^ADDR_W; wrap from max to 0 is silent.
//  - Latency: a redirect on inputs at edge N makes pc_out equal the target after edge N.
//    pc_next always equals that value, and so does pc_next while rst=1 (RESET_VEC).
//  - stall=1: pc_out, RAS and count unchanged; ret_fault <= 0.
//  - jump: pc_out <= jump_target; RAS untouched.
//  - call: pc_out <= jump_target; push pc_plus.
//    Push when full drops the oldest entry (circular); count stays RAS_DEPTH.
//  - ret, RAS not empty: pc_out <= top entry; pop; count-1.
//  - ret, RAS empty: pc_out <= pc_plus; ret_fault <= 1 for one cycle.
//  - call+ret in the same cycle: ret wins for the target.
//    The popped slot is overwritten with pc_plus, so the count is unchanged (tail return).
//    If the RAS is empty: pc_out <= pc_plus, ret_fault pulses, and the push becomes a
//    normal push (count=1).
//  - ret_fault <= 0 in every cycle that does not meet the pulse conditions above.
//  - Targets are taken verbatim; no alignment or range checks.
// CONFIGURATION
//  - PC_RAS_EN defined: RAS built as described (RAS_DEPTH x ADDR_W register array +
//    pointer + count).
//  - PC_RAS_EN undefined: no storage.
//    - call behaves exactly as jump.
//    - ret behaves as the empty-RAS case (pc_out <= pc_plus, ret_fault pulses).
//    - ras_empty tied 1, ras_full tied 0.
//    - RAS_DEPTH ignored.
// TESTING
//  - rst=1 for 2 cycles, then idle 3 cycles (RESET_VEC=0, STEP=1) -> pc_out 0,0,1,2,3;
//    pc_next leads pc_out by one cycle.
//  - pc_out=0x10, stall=1 with branch_taken=1, target 0x40, for 3 cycles -> pc_out stays
//    0x10. Release -> 0x40, then 0x41.
//  - ADDR_W=8, start 0xFE, no control -> 0xFF, then 0x00. Both branch_taken and jump
//    asserted -> jump_target taken.
//  - PC_RAS_EN, RAS_DEPTH=4:
//    - calls at pc 0x10,0x20,0x30,0x40,0x50 -> ras_full after the 4th;
//    - 5 rets -> returns to 0x51,0x41,0x31,0x21;
//    - 5th ret -> ret_fault pulses 1 cycle and pc_out = previous+1.
//  - PC_RAS_EN, one entry 0x11: call+ret with jump_target 0x80 at pc 0x30 ->
//    pc_out 0x11, RAS top 0x31, count 1.
//  - rst asserted mid-sequence with 3 RAS entries -> pc_out=RESET_VEC, ras_empty=1.
//    Next ret -> ret_fault pulse. With PC_RAS_EN undefined, call == jump and no state kept.

Source files
------------

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: control and address bundle between a fetch controller and pc_sequencer.
//   master : drives stall/branch/jump/call/ret requests and targets, reads PC and RAS status
//   slave  : the sequencer; consumes the requests, produces pc_out/pc_plus/pc_next and
//            the ras_empty/ras_full/ret_fault status
// ADDR_W must match the ADDR_W of the attached pc_sequencer.
interface pc_sequencer_if #(
   parameter int ADDR_W = 32
);
   logic              stall;
   logic              branch_taken;
   logic [ADDR_W-1:0] branch_target;
   logic              jump;
   logic              call;
   logic [ADDR_W-1:0] jump_target;
   logic              ret;
   logic [ADDR_W-1:0] pc_out;
   logic [ADDR_W-1:0] pc_plus;
   logic [ADDR_W-1:0] pc_next;
   logic              ras_empty;
   logic              ras_full;
   logic              ret_fault;

   modport master (
      output stall, branch_taken, branch_target, jump, call, jump_target, ret,
      input  pc_out, pc_plus, pc_next, ras_empty, ras_full, ret_fault
   );

   modport slave (
      input  stall, branch_taken, branch_target, jump, call, jump_target, ret,
      output pc_out, pc_plus, pc_next, ras_empty, ras_full, ret_fault
   );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter unit. Registers the fetch address and selects the next
// one from sequential step, branch, jump, call or return.
//   clk  : clock, all state changes on posedge
//   rst  : synchronous active-high reset (pc_out=RESET_VEC, RAS cleared, no fault)
//   bus  : pc_sequencer_if.slave
//          inputs  stall, branch_taken, branch_target, jump, call, jump_target, ret
//          outputs pc_out (registered), pc_plus (pc_out+STEP), pc_next (next pc_out),
//                  ras_empty, ras_full, ret_fault (registered 1-cycle pulse)
// Priority each cycle: rst > stall > ret > call > jump > branch_taken > sequential.
// Build option: define PC_RAS_EN to build the return-address stack (RAS_DEPTH entries,
// circular, oldest entry dropped on overflow). Without it call acts as jump, ret always
// takes the empty-stack path, ras_empty=1 and ras_full=0.
module pc_sequencer #(
   parameter int ADDR_W    = 32,
   parameter int STEP      = 1,
   parameter int RESET_VEC = 0,
   parameter int RAS_DEPTH = 4
) (
   input  logic            clk,
   input  logic            rst,
   pc_sequencer_if.slave   bus
);

   localparam logic [ADDR_W-1:0] STEP_V  = ADDR_W'(STEP);
   localparam logic [ADDR_W-1:0] RESET_V = ADDR_W'(RESET_VEC);

   if (RAS_DEPTH < 2) begin : g_bad_depth
      $error("pc_sequencer: RAS_DEPTH must be at least 2");
   end

   logic [ADDR_W-1:0] pc_q;
   logic [ADDR_W-1:0] pc_plus_c;
   logic [ADDR_W-1:0] pc_next_c;
   logic              ret_fault_q;
   logic              ras_empty_c;
   logic              ras_full_c;
   logic              ret_pop;
   logic [ADDR_W-1:0] ras_top;

   assign pc_plus_c = pc_q + STEP_V;

`ifdef PC_RAS_EN
   localparam int PTR_W = $clog2(RAS_DEPTH);
   localparam int CNT_W = $clog2(RAS_DEPTH + 1);
   localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(RAS_DEPTH - 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RAS_DEPTH);

   logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];
   logic [PTR_W-1:0]  wr_ptr;     // next free slot; top of stack is the slot below it
   logic [CNT_W-1:0]  ras_cnt;
   logic [PTR_W-1:0]  top_ptr;
   logic [PTR_W-1:0]  inc_ptr;

   // explicit wrap so non-power-of-two depths stay circular
   assign top_ptr     = (wr_ptr == '0)      ? PTR_MAX : wr_ptr - 1'b1;
   assign inc_ptr     = (wr_ptr == PTR_MAX) ? '0      : wr_ptr + 1'b1;
   assign ras_empty_c = (ras_cnt == '0);
   assign ras_full_c  = (ras_cnt == CNT_MAX);
   assign ras_top     = ras_mem[top_ptr];
   assign ret_pop     = bus.ret && !ras_empty_c;

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr  <= '0;
         ras_cnt <= '0;
      end else if (!bus.stall) begin
         if (ret_pop && bus.call) begin
            // tail return: reuse the popped slot for the new link, depth unchanged
            ras_mem[top_ptr] <= pc_plus_c;
         end else if (ret_pop) begin
            wr_ptr  <= top_ptr;
            ras_cnt <= ras_cnt - 1'b1;
         end else if (bus.call) begin
            // when full this overwrites the oldest entry; count saturates
            ras_mem[wr_ptr] <= pc_plus_c;
            wr_ptr          <= inc_ptr;
            if (!ras_full_c) begin
               ras_cnt <= ras_cnt + 1'b1;
            end
         end
      end
   end
`else
   assign ras_empty_c = 1'b1;
   assign ras_full_c  = 1'b0;
   assign ret_pop     = 1'b0;
   assign ras_top     = '0;
`endif

   always_comb begin
      pc_next_c = pc_plus_c;
      if (rst) begin
         pc_next_c = RESET_V;
      end else if (bus.stall) begin
         pc_next_c = pc_q;
      end else if (bus.ret) begin
         pc_next_c = ret_pop ? ras_top : pc_plus_c;
      end else if (bus.call || bus.jump) begin
         pc_next_c = bus.jump_target;
      end else if (bus.branch_taken) begin
         pc_next_c = bus.branch_target;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q        <= RESET_V;
         ret_fault_q <= 1'b0;
      end else begin
         pc_q        <= pc_next_c;
         ret_fault_q <= !bus.stall && bus.ret && ras_empty_c;
      end
   end

   assign bus.pc_out    = pc_q;
   assign bus.pc_plus   = pc_plus_c;
   assign bus.pc_next   = pc_next_c;
   assign bus.ras_empty = ras_empty_c;
   assign bus.ras_full  = ras_full_c;
   assign bus.ret_fault = ret_fault_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed bench for pc_sequencer with ADDR_W=8, STEP=1, RESET_VEC=0,
// RAS_DEPTH=4. A vector table covers reset, stepping, stall, branch/jump priority and
// wrap; hand sequences cover call/ret behaviour for whichever build (PC_RAS_EN or not).
module tb_pc_sequencer;

   logic clk = 1'b0;
   logic rst;
   int   n_checks = 0;
   int   n_errors = 0;

   always #5 clk = ~clk;

   pc_sequencer_if #(.ADDR_W(8)) bus ();

   pc_sequencer #(
      .ADDR_W   (8),
      .STEP     (1),
      .RESET_VEC(0),
      .RAS_DEPTH(4)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.slave)
   );

   typedef struct packed {
      logic       rst;
      logic       stall;
      logic       br;
      logic [7:0] bt;
      logic       jmp;
      logic [7:0] jt;
      logic [7:0] pc;
   } vec_t;

   vec_t tbl [18];

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
      end
   endtask

   // Applies one cycle of inputs, checks pc_next before the edge and registered
   // outputs just after it. exp_pc is the pc_out value expected after the edge.
   task automatic cyc(input string name, input logic r, input logic s, input logic br,
                      input logic [7:0] bt, input logic jp, input logic cl, input logic rt,
                      input logic [7:0] jt, input logic [7:0] exp_pc,
                      input logic exp_fault, input logic exp_empty, input logic exp_full);
      logic [7:0] exp_plus;
      rst               = r;
      bus.stall         = s;
      bus.branch_taken  = br;
      bus.branch_target = bt;
      bus.jump          = jp;
      bus.call          = cl;
      bus.ret           = rt;
      bus.jump_target   = jt;
      @(negedge clk);
      chk({name, ".pc_next"}, bus.pc_next, exp_pc);
      @(posedge clk);
      #1;
      exp_plus = exp_pc + 8'd1;
      chk({name, ".pc_out"},    bus.pc_out, exp_pc);
      chk({name, ".pc_plus"},   bus.pc_plus, exp_plus);
      chk({name, ".ret_fault"}, {7'd0, bus.ret_fault}, {7'd0, exp_fault});
      chk({name, ".ras_empty"}, {7'd0, bus.ras_empty}, {7'd0, exp_empty});
      chk({name, ".ras_full"},  {7'd0, bus.ras_full},  {7'd0, exp_full});
   endtask

   initial begin
      //          rst  stall br  bt     jmp jt     pc
      tbl[0]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00};
      tbl[1]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00};
      tbl[2]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 8'h01};
      tbl[3]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 8'h02};
      tbl[4]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 8'h03};
      tbl[5]  = '{1'b0, 1'b0, 1'b1, 8'h10, 1'b0, 8'h00, 8'h10};
      tbl[6]  = '{1'b0, 1'b1, 1'b1, 8'h40, 1'b0, 8'h00, 8'h10};
      tbl[7]  = '{1'b0, 1'b1, 1'b1, 8'h40, 1'b0, 8'h00, 8'h10};
      tbl[8]  = '{1'b0, 1'b1, 1'b1, 8'h40, 1'b0, 8'h00, 8'h10};
      tbl[9]  = '{1'b0, 1'b0, 1'b1, 8'h40, 1'b0, 8'h00, 8'h40};
      tbl[10] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 8'h41};
      tbl[11] = '{1'b0, 1'b0, 1'b1, 8'h20, 1'b1, 8'hFE, 8'hFE};
      tbl[12] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 8'hFF};
      tbl[13] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00};
      tbl[14] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h55, 8'h00};
      tbl[15] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h55, 8'h55};
      tbl[16] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h77, 8'h00};
      tbl[17] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 8'h01};

      rst = 1'b1;
      bus.stall = 1'b0; bus.branch_taken = 1'b0; bus.branch_target = '0;
      bus.jump = 1'b0; bus.call = 1'b0; bus.ret = 1'b0; bus.jump_target = '0;

      for (int i = 0; i < 18; i++) begin
         cyc($sformatf("vec%0d", i), tbl[i].rst, tbl[i].stall, tbl[i].br, tbl[i].bt,
             tbl[i].jmp, 1'b0, 1'b0, tbl[i].jt, tbl[i].pc, 1'b0, 1'b1, 1'b0);
      end

`ifdef PC_RAS_EN
      // fill past capacity: links 0x11..0x51, 0x11 dropped on the 5th call
      cyc("ras_rst",   1, 0, 0, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0, 1, 0);
      cyc("ras_j10",   0, 0, 0, 8'h00, 1, 0, 0, 8'h10, 8'h10, 0, 1, 0);
      cyc("call1",     0, 0, 0, 8'h00, 0, 1, 0, 8'h20, 8'h20, 0, 0, 0);
      cyc("call2",     0, 0, 0, 8'h00, 0, 1, 0, 8'h30, 8'h30, 0, 0, 0);
      cyc("call3",     0, 0, 0, 8'h00, 0, 1, 0, 8'h40, 8'h40, 0, 0, 0);
      cyc("call4",     0, 0, 0, 8'h00, 0, 1, 0, 8'h50, 8'h50, 0, 0, 1);
      cyc("call5",     0, 0, 0, 8'h00, 0, 1, 0, 8'h60, 8'h60, 0, 0, 1);
      cyc("stall_ret", 0, 1, 0, 8'h00, 0, 0, 1, 8'h00, 8'h60, 0, 0, 1);
      cyc("ret1",      0, 0, 0, 8'h00, 0, 0, 1, 8'h00, 8'h51, 0, 0, 0);
      cyc("ret2",      0, 0, 0, 8'h00, 0, 0, 1, 8'h00, 8'h41, 0, 0, 0);
      cyc("ret3",      0, 0, 0, 8'h00, 0, 0, 1, 8'h00, 8'h31, 0, 0, 0);
      cyc("ret4",      0, 0, 0, 8'h00, 0, 0, 1, 8'h00, 8'h21, 0, 1, 0);
      cyc("ret5",      0, 0, 0, 8'h00, 0, 0, 1, 8'h00, 8'h22, 1, 1, 0);
      cyc("post_ret5", 0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 8'h23, 0, 1, 0);

      // tail return with one entry 0x11
      cyc("tail_j10",  0, 0, 0, 8'h00, 1, 0, 0, 8'h10, 8'h10, 0, 1, 0);
      cyc("tail_call", 0, 0, 0, 8'h00, 0, 1, 0, 8'h30, 8'h30, 0, 0, 0);
      cyc("tail_cr",   0, 0, 0, 8'h00, 0, 1, 1, 8'h80, 8'h11, 0, 0, 0);
      cyc("tail_ret",  0, 0, 0, 8'h00, 0, 0, 1, 8'h00, 8'h31, 0, 1, 0);
      cyc("tail_ret2", 0, 0, 0, 8'h00, 0, 0, 1, 8'h00, 8'h32, 1, 1, 0);

      // call+ret on an empty stack: fault plus a normal push of the link
      cyc("ecr",       0, 0, 0, 8'h00, 0, 1, 1, 8'h80, 8'h33, 1, 0, 0);
      cyc("ecr_ret",   0, 0, 0, 8'h00, 0, 0, 1, 8'h00, 8'h33, 0, 1, 0);

      // reset with three entries discards them
      cyc("mr_c1",     0, 0, 0, 8'h00, 0, 1, 0, 8'h40, 8'h40, 0, 0, 0);
      cyc("mr_c2",     0, 0, 0, 8'h00, 0, 1, 0, 8'h50, 8'h50, 0, 0, 0);
      cyc("mr_c3",     0, 0, 0, 8'h00, 0, 1, 0, 8'h60, 8'h60, 0, 0, 0);
      cyc("mr_rst",    1, 0, 0, 8'h00, 0, 0, 1, 8'h00, 8'h00, 0, 1, 0);
      cyc("mr_ret",    0, 0, 0, 8'h00, 0, 0, 1, 8'h00, 8'h01, 1, 1, 0);
      cyc("mr_idle",   0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 8'h02, 0, 1, 0);
`else
      // no stack: call is a jump, ret always faults and steps
      cyc("nr_rst",    1, 0, 0, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0, 1, 0);
      cyc("nr_j10",    0, 0, 0, 8'h00, 1, 0, 0, 8'h10, 8'h10, 0, 1, 0);
      cyc("nr_call",   0, 0, 0, 8'h00, 0, 1, 0, 8'h30, 8'h30, 0, 1, 0);
      cyc("nr_call2",  0, 0, 0, 8'h00, 0, 1, 0, 8'h40, 8'h40, 0, 1, 0);
      cyc("nr_ret",    0, 0, 0, 8'h00, 0, 0, 1, 8'h00, 8'h41, 1, 1, 0);
      cyc("nr_cr",     0, 0, 0, 8'h00, 0, 1, 1, 8'h80, 8'h42, 1, 1, 0);
      cyc("nr_idle",   0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 8'h43, 0, 1, 0);
      cyc("nr_sret",   0, 1, 0, 8'h00, 0, 0, 1, 8'h00, 8'h43, 0, 1, 0);
      cyc("nr_mrst",   1, 0, 0, 8'h00, 0, 0, 1, 8'h00, 8'h00, 0, 1, 0);
      cyc("nr_ret2",   0, 0, 0, 8'h00, 0, 0, 1, 8'h00, 8'h01, 1, 1, 0);
      cyc("nr_idle2",  0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 8'h02, 0, 1, 0);
`endif

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
